// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types, constants and GF(2^8) helpers for the AES
//                iterative round engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int c_width  = 8;
    localparam int c_dim    = 4;
    localparam int c_blk    = c_width * c_dim * c_dim;
    localparam int c_nr_min = 2;
    localparam int c_nr_max = 15;

    // Element [c][r] is column c, row r; FIPS byte n = r + 4c.
    typedef logic [c_dim-1:0][c_dim-1:0][c_width-1:0] matrix_t;

    localparam matrix_t c_zero_mat = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_state_t;

    // The bus carries byte 0 in the MSBs; the matrix keeps byte 0 at the LSBs.
    function automatic matrix_t vec2mat(input logic [c_blk-1:0] v);
        return matrix_t'({<<c_width{v}});
    endfunction

    function automatic logic [c_blk-1:0] mat2vec(input matrix_t m);
        return {<<c_width{m}};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_engine_if
//  Description : Plaintext-in / ciphertext-out valid/ready bundle for the
//                AES round engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_engine_if
    import aes_pkg::*;
#(
    parameter int NR  = 10,
    parameter int BLK = c_blk
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [BLK-1:0]        data_i;
    logic [(NR+1)*BLK-1:0] rkeys_i;
    logic                  abort_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [BLK-1:0]        data_o;
    logic [3:0]            round_o;

    modport master (
        output in_valid_i, data_i, rkeys_i, abort_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, round_o
    );

    modport slave (
        input  in_valid_i, data_i, rkeys_i, abort_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, round_o
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_dp.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_dp
//  Description : Combinational AES round: SubBytes, ShiftRows, MixColumns
//                (bypassed on the last round) and AddRoundKey.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_dp
    import aes_pkg::*;
(
    input  matrix_t i_state,
    input  matrix_t i_rkey,
    input  logic    i_last,
    output matrix_t o_state
);
    wire matrix_t w_sub;
    wire matrix_t w_shift;
    wire matrix_t w_mix;
    wire matrix_t w_pre_key;

    for (genvar c = 0; c < c_dim; c++) begin : g_col
        for (genvar r = 0; r < c_dim; r++) begin : g_row
            assign w_sub[c][r]   = sbox(i_state[c][r]);
            // Row r rotates left by r columns.
            assign w_shift[c][r] = w_sub[(c + r) % c_dim][r];
        end

        wire [7:0] w_a0 = w_shift[c][0];
        wire [7:0] w_a1 = w_shift[c][1];
        wire [7:0] w_a2 = w_shift[c][2];
        wire [7:0] w_a3 = w_shift[c][3];

        assign w_mix[c][0] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mix[c][1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign w_mix[c][2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign w_mix[c][3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

    assign w_pre_key = i_last ? w_shift : w_mix;
    assign o_state   = w_pre_key ^ i_rkey;

endmodule
`default_nettype wire

// File: rtl/aes_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_engine
//  Description : Iterative AES encryption engine, one round per clock, with
//                valid/ready handshakes on plaintext input and ciphertext output.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int DIM   = c_dim,
    parameter int NR    = 10,
    localparam int BLK  = WIDTH * DIM * DIM
)(
    input  logic              clk_i,
    input  logic              rst_ni,
    aes_round_engine_if.slave bus
);
    localparam logic [3:0] c_nr = 4'(NR);

    if (WIDTH != c_width || DIM != c_dim || NR < c_nr_min || NR > c_nr_max) begin : g_param_check
        $error("aes_round_engine: unsupported WIDTH/DIM/NR");
    end

    fsm_state_t     r_state;
    fsm_state_t     w_state_nxt;
    logic [3:0]     r_round;
    logic [3:0]     w_round_nxt;
    matrix_t        r_mat;
    matrix_t        w_mat_nxt;
    matrix_t        w_load;
    matrix_t        w_rkey_mat;
    matrix_t        w_dp_out;
    logic [BLK-1:0] w_keys [0:NR];
    logic           w_last;
    logic           w_in_fire;

    for (genvar k = 0; k <= NR; k++) begin : g_key
        assign w_keys[k] = bus.rkeys_i[k*BLK +: BLK];
    end

    assign w_rkey_mat = vec2mat(w_keys[r_round]);
    assign w_load     = vec2mat(bus.data_i ^ w_keys[0]);
    assign w_last     = (r_round == c_nr);

    aes_round_dp u_round_dp (
        .i_state (r_mat),
        .i_rkey  (w_rkey_mat),
        .i_last  (w_last),
        .o_state (w_dp_out)
    );

    // Accepting in DONE overlaps the output handshake so there is no idle bubble.
    assign bus.in_ready_o  = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready_i);
    assign w_in_fire       = bus.in_valid_i & bus.in_ready_o;
    assign bus.out_valid_o = (r_state == DONE);
    assign bus.data_o      = bus.out_valid_o ? mat2vec(r_mat) : '0;
    assign bus.round_o     = r_round;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_round <= 4'd0;
            r_mat   <= c_zero_mat;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_mat   <= w_mat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_mat_nxt   = r_mat;
        if (bus.abort_i) begin
            w_state_nxt = IDLE;
            w_round_nxt = 4'd0;
            w_mat_nxt   = c_zero_mat;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        w_state_nxt = ROUND;
                        w_round_nxt = 4'd1;
                        w_mat_nxt   = w_load;
                    end
                end
                ROUND: begin
                    w_mat_nxt = w_dp_out;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_round_nxt = r_round + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        if (bus.in_valid_i) begin
                            w_state_nxt = ROUND;
                            w_round_nxt = 4'd1;
                            w_mat_nxt   = w_load;
                        end else begin
                            w_state_nxt = IDLE;
                            w_round_nxt = 4'd0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_round_nxt = 4'd0;
                    w_mat_nxt   = c_zero_mat;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_engine
//  Description : Directed FIPS-197 vectors against NR=10 and NR=14 engines.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_engine;

    localparam logic [127:0] c_key_b  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_pt_b   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_pt_c   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] c_key_c3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_ct_c3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n;

    logic [7:0]          sb [0:255];
    logic [15*128-1:0]   rk_b;
    logic [15*128-1:0]   rk_c1;
    logic [15*128-1:0]   rk_c3;

    always #5 clk = ~clk;

    aes_round_engine_if #(.NR(10)) ifa ();
    aes_round_engine_if #(.NR(14)) ifb ();

    aes_round_engine #(.NR(10)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
    aes_round_engine #(.NR(14)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // Inverse found by exhaustive search, independent of the design's method.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [15*128-1:0] expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]       w [0:59];
        logic [31:0]       t;
        logic [7:0]        rc;
        logic [15*128-1:0] o;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        o = '0;
        for (int r = 0; r <= nr; r++)
            o[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept_a(input logic [127:0] pt, input logic [15*128-1:0] rk);
        ifa.data_i     = pt;
        ifa.rkeys_i    = rk[11*128-1:0];
        ifa.in_valid_i = 1'b1;
        tick();
        ifa.in_valid_i = 1'b0;
    endtask

    // Edges after the accept edge until out_valid_o; 40 means timed out.
    task automatic wait_a(output int cnt);
        cnt = 0;
        while (ifa.out_valid_o !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        build_sbox();
        rk_b  = expand({c_key_b, 128'h0}, 4, 10);
        rk_c1 = expand({c_key_c1, 128'h0}, 4, 10);
        rk_c3 = expand(c_key_c3, 8, 14);

        ifa.in_valid_i = 1'b0; ifa.data_i = '0; ifa.rkeys_i = '0;
        ifa.abort_i    = 1'b0; ifa.out_ready_i = 1'b1;
        ifb.in_valid_i = 1'b0; ifb.data_i = '0; ifb.rkeys_i = '0;
        ifb.abort_i    = 1'b0; ifb.out_ready_i = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  128'(ifa.in_ready_o),  128'd1);
        chk("rst_out_valid", 128'(ifa.out_valid_o), 128'd0);
        chk("rst_data_o",    ifa.data_o,            128'd0);
        chk("rst_round_o",   128'(ifa.round_o),     128'd0);
        rst_n = 1'b1;
        tick();

        // App. B, sink always ready
        accept_a(c_pt_b, rk_b);
        chk("b_round_after_accept", 128'(ifa.round_o), 128'd1);
        wait_a(n);
        chk("b_latency",   128'(n),          128'd10);
        chk("b_ct",        ifa.data_o,       c_ct_b);
        chk("b_round_sat", 128'(ifa.round_o), 128'd10);
        tick();
        chk("b_one_cycle", 128'(ifa.out_valid_o), 128'd0);
        chk("b_data_zero", ifa.data_o,            128'd0);

        // Backpressure
        ifa.out_ready_i = 1'b0;
        accept_a(c_pt_b, rk_b);
        wait_a(n);
        chk("bp_latency", 128'(n), 128'd10);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data",  ifa.data_o,            c_ct_b);
            chk("bp_hold_valid", 128'(ifa.out_valid_o), 128'd1);
            chk("bp_in_ready",   128'(ifa.in_ready_o),  128'd0);
            tick();
        end
        ifa.out_ready_i = 1'b1;
        tick();
        chk("bp_released", 128'(ifa.out_valid_o), 128'd0);

        // Back-to-back: new block presented while the previous one is in DONE
        accept_a(c_pt_b, rk_b);
        wait_a(n);
        chk("b2b_first_ct", ifa.data_o, c_ct_b);
        ifa.data_i     = c_pt_c;
        ifa.rkeys_i    = rk_c1[11*128-1:0];
        ifa.in_valid_i = 1'b1;
        chk("b2b_in_ready", 128'(ifa.in_ready_o), 128'd1);
        tick();
        ifa.in_valid_i = 1'b0;
        chk("b2b_round_1", 128'(ifa.round_o), 128'd1);
        wait_a(n);
        chk("b2b_gap",       128'(n + 1), 128'd11);
        chk("b2b_second_ct", ifa.data_o, c_ct_c1);
        tick();

        // Abort at round 4, with a competing in_valid_i
        accept_a(c_pt_b, rk_b);
        repeat (3) tick();
        chk("ab_round4", 128'(ifa.round_o), 128'd4);
        ifa.abort_i    = 1'b1;
        ifa.in_valid_i = 1'b1;
        ifa.data_i     = c_pt_c;
        tick();
        ifa.abort_i    = 1'b0;
        ifa.in_valid_i = 1'b0;
        chk("ab_in_ready",  128'(ifa.in_ready_o),  128'd1);
        chk("ab_out_valid", 128'(ifa.out_valid_o), 128'd0);
        chk("ab_data_o",    ifa.data_o,            128'd0);
        chk("ab_round_o",   128'(ifa.round_o),     128'd0);
        accept_a(c_pt_c, rk_c1);
        wait_a(n);
        chk("ab_next_latency", 128'(n),    128'd10);
        chk("ab_next_ct",      ifa.data_o, c_ct_c1);
        tick();

        // Asynchronous reset in the middle of ROUND
        accept_a(c_pt_b, rk_b);
        repeat (3) tick();
        chk("rs_round_before", 128'(ifa.round_o), 128'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_round_o",   128'(ifa.round_o),     128'd0);
        chk("rs_in_ready",  128'(ifa.in_ready_o),  128'd1);
        chk("rs_out_valid", 128'(ifa.out_valid_o), 128'd0);
        chk("rs_data_o",    ifa.data_o,            128'd0);
        #2 rst_n = 1'b1;
        tick();
        accept_a(c_pt_b, rk_b);
        wait_a(n);
        chk("rs_after_latency", 128'(n),    128'd10);
        chk("rs_after_ct",      ifa.data_o, c_ct_b);
        tick();

        // NR = 14, App. C.3
        ifb.data_i      = c_pt_c;
        ifb.rkeys_i     = rk_c3;
        ifb.in_valid_i  = 1'b1;
        tick();
        ifb.in_valid_i  = 1'b0;
        ifb.out_ready_i = 1'b0;
        n = 0;
        while (ifb.out_valid_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("c3_latency", 128'(n),          128'd14);
        chk("c3_ct",      ifb.data_o,       c_ct_c3);
        chk("c3_round",   128'(ifb.round_o), 128'd14);
        repeat (2) tick();
        chk("c3_round_sat", 128'(ifb.round_o),     128'd14);
        chk("c3_hold",      ifb.data_o,            c_ct_c3);
        ifb.out_ready_i = 1'b1;
        tick();
        chk("c3_done_valid", 128'(ifb.out_valid_o), 128'd0);
        chk("c3_done_round", 128'(ifb.round_o),     128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
